uart_rx_deserializer: RTL

Receive-side UART front end that turns the serial posi line into validated bytes for the configuration register-map command decoder. It synchronizes posi and times each bit with a counter of system clocks per bit. It checks start and stop framing and delivers each byte through a valid/ready handshake with overrun detection. It sits between the posi pad and the packet/regmap logic inside the chip's external interface.

---
 rtl/uart_rx_deserializer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-flop posi synchronizer, mid-bit sampling FSM, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between the last data bit and the stop bit.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 posi,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    input  logic                 clear_errors,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [CW-1:0]        clkCnt_q;
    logic [BW-1:0]        bitCnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q;
    logic                 frameError_q;
    logic                 overrun_q;
    logic                 posiS;
    logic                 byteGood;
`ifdef UART_RX_PARITY_EN
    logic                 parityError_q;
    logic                 parityBad_q;
`endif

    assign posiS = sync_q[1];

`ifdef UART_RX_PARITY_EN
    assign byteGood = posiS && !parityBad_q;
`else
    assign byteGood = posiS;
`endif

    // Every sample point after the start check is one full bit period after the previous one,
    // so all of them land mid-bit; the stop decision delivers the byte without waiting out the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            clkCnt_q     <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            frameError_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityError_q <= 1'b0;
            parityBad_q   <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], posi};
            frameError_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityError_q <= 1'b0;
`endif
            if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end
            if (clear_errors) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!posiS) begin
                        state_q  <= START;
                        clkCnt_q <= '0;
                        bitCnt_q <= '0;
                    end
                end
                START: begin
                    if (clkCnt_q == HALF_LAST) begin
                        clkCnt_q <= '0;
                        bitCnt_q <= '0;
                        state_q  <= posiS ? IDLE : DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q <= '0;
                        shift_q  <= {posiS, shift_q[DATA_BITS-1:1]};
                        if (bitCnt_q == DATA_LAST) begin
                            bitCnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q  <= PARITY;
`else
                            state_q  <= STOP;
`endif
                        end else begin
                            bitCnt_q <= bitCnt_q + BW'(1);
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q    <= '0;
                        parityBad_q <= (^shift_q) ^ posiS;
                        state_q     <= STOP;
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q     <= '0;
                        state_q      <= IDLE;
                        frameError_q <= !posiS;
`ifdef UART_RX_PARITY_EN
                        parityError_q <= parityBad_q;
`endif
                        // A fresh byte overrides the handshake clear; if the old one is still
                        // pending the new one is dropped and overrun wins over clear_errors.
                        if (byteGood) begin
                            if (!rxValid_q || rx_ready) begin
                                rxData_q  <= shift_q;
                                rxValid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign frame_error = frameError_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = parityError_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
